sr_pulse_driver: RTL and testbench
==================================

Name: sr_pulse_driver

Overview:
- Synchronous stimulus transmitter that drives the set input (A side) and reset input (B side) of the NOR SR-latch delay-chain fixture.
- Accepts pulse commands over a valid/ready interface and produces registered, cycle-exact pulses with programmable width and trailing gap.
- Can deliberately assert both inputs together to exercise the forbidden NOR-latch state.
- Sits between the test sequencer and the latch fixture inputs.

Parameters:
- WIDTH_W, 8, bit width of the pulse-width field.
- GAP_W, 8, bit width of the gap field.
- MIN_GAP, 1, number of low cycles always appended after every pulse; legal range is 1 or more.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  operation: 00 SET, 01 RESET, 10 BOTH, 11 NOP.
- cmd_width  in  WIDTH_W  pulse high time in cycles; 0 is treated as 1.
- cmd_gap  in  GAP_W  extra low cycles after the pulse, added to MIN_GAP.
- set_o  out  1  drives the latch A (set) input chain.
- reset_o  out  1  drives the latch B (reset) input chain.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle strobe when a command completes.
- pulse_count  out  16  number of non-NOP pulses issued; saturates at 0xFFFF.

Behaviour:
- Reset is asynchronous and active-low. One clock: clk. While rst_n=0, all of these are forced immediately: set_o=0, reset_o=0, busy=0, done=0, cmd_ready=0, pulse_count=0, state=IDLE. cmd_ready=1 from the first clock edge after rst_n deasserts.
- FSM states: IDLE, PULSE, GAP.
  - IDLE: cmd_ready=1. If cmd_valid is high, the command is accepted (cycle T): op, width and gap are latched, and the FSM moves to PULSE.
  - PULSE: lasts W = max(cmd_width,1) cycles, T+1 through T+W. Outputs per op:
    - SET: set_o=1.
    - RESET: reset_o=1.
    - BOTH: set_o=1 and reset_o=1 in the same cycles.
    - NOP: both outputs stay 0.
  - GAP: lasts cmd_gap+MIN_GAP cycles, T+W+1 through T+W+cmd_gap+MIN_GAP. Both outputs are 0.
  - Return to IDLE in the next cycle (call it E). In cycle E: done=1 for exactly one cycle and cmd_ready=1. A command presented in cycle E is accepted, so back-to-back commands have no dead cycle.
- Outputs set_o and reset_o come straight from flops with no combinational path from the inputs. They never glitch within a cycle, and SET/RESET pulses never overlap.
- pulse_count increments at the PULSE entry edge for SET, RESET and BOTH. It does not increment for NOP. It holds at 0xFFFF once saturated.
- cmd_ready=0 in PULSE and GAP. cmd_valid in those states is ignored. Command fields are sampled only at acceptance, so later changes have no effect.
- Width arithmetic: down-counter of max(WIDTH_W, GAP_W+1) bits. The sum cmd_gap+MIN_GAP is computed one bit wider so it never wraps. Maximum-value fields (0xFF, 0xFF) must produce 255 high cycles followed by 255+MIN_GAP low cycles.
- Reset mid-PULSE drops the outputs asynchronously. The in-flight command is discarded and no done is issued.

Optional Feature:
- Macro: SR_PULSE_DRIVER_CHECK_EN.
- With the macro defined:
  - Extra inputs q_i and q_n_i, taken from the latch outputs, each passed through a 2-flop synchronizer.
  - Extra outputs check_err (1 bit, sticky until reset) and err_count (8 bits, saturating).
  - Check point: the last GAP cycle, on the synchronized values.
  - After SET, the required values are q=1, q_n=0. After RESET, q=0, q_n=1. A mismatch sets check_err and increments err_count.
  - BOTH and NOP are never checked.
  - If cmd_gap+MIN_GAP < 3, the check is skipped because the synchronizer has not settled.
- Without the macro: the ports and the logic are absent.

Decomposition:
- Package sr_pulse_pkg contains:
  - op enum: OP_SET, OP_RESET, OP_BOTH, OP_NOP.
  - state enum: ST_IDLE, ST_PULSE, ST_GAP.
  - default constants: WIDTH_W, GAP_W, MIN_GAP.
  - PULSE_CNT_MAX = 16'hFFFF.
- One sub-module, sync2 (2-flop synchronizer), instantiated only under SR_PULSE_DRIVER_CHECK_EN.

Test Plan:
- Accept SET with width=3, gap=2, MIN_GAP=1 at cycle T: set_o=1 on T+1..T+3, 0 on T+4..T+6; done=1 and cmd_ready=1 at T+7; pulse_count=1.
- RESET with width=0: reset_o=1 for exactly 1 cycle (T+1); set_o stays 0 throughout.
- BOTH with width=5: set_o and reset_o are both high on the same 5 cycles. NOP with width=5: both outputs stay low, done still fires, pulse_count is unchanged.
- Hold cmd_valid high with SET then RESET back-to-back: second command accepted in the done cycle; reset_o rises exactly gap+MIN_GAP+1 cycles after set_o falls.
- Drop rst_n in the middle of a SET with width=200: set_o=0 in the same cycle (asynchronous); no done; after release cmd_ready=1 and pulse_count=0.
- With the check macro, SET with gap=4 but model drives q_i=0: check_err=1 and err_count=1. With gap=0 and MIN_GAP=1: no check and no error.

Source files
------------

// File: rtl/sr_pulse_pkg.sv
// sr_pulse_pkg: shared types and default constants for the SR-latch pulse driver
package sr_pulse_pkg;
  typedef enum logic [1:0] {OP_SET = 2'b00, OP_RESET = 2'b01, OP_BOTH = 2'b10, OP_NOP = 2'b11} op_t;
  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_GAP} state_t;
  localparam int WIDTH_W = 8;
  localparam int GAP_W = 8;
  localparam int MIN_GAP = 1;
  localparam logic [15:0] PULSE_CNT_MAX = 16'hFFFF;
endpackage

// File: rtl/sr_pulse_driver_sync2.sv
// sync2: two-flop synchronizer for latch feedback, present only with SR_PULSE_DRIVER_CHECK_EN
`ifdef SR_PULSE_DRIVER_CHECK_EN
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= 1'b0;
      q <= 1'b0;
    end else begin
      m <= d;
      q <= m;
    end
  end
endmodule
`endif

// File: rtl/sr_pulse_driver.sv
// sr_pulse_driver: cycle-exact set/reset pulse generator for the NOR SR-latch fixture
// Optional latch feedback checking with SR_PULSE_DRIVER_CHECK_EN.
module sr_pulse_driver #(
  parameter int WIDTH_W = sr_pulse_pkg::WIDTH_W,
  parameter int GAP_W = sr_pulse_pkg::GAP_W,
  parameter int MIN_GAP = sr_pulse_pkg::MIN_GAP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [WIDTH_W-1:0] cmd_width,
  input  logic [GAP_W-1:0]   cmd_gap,
  output logic               set_o,
  output logic               reset_o,
  output logic               busy,
  output logic               done,
  output logic [15:0]        pulse_count
`ifdef SR_PULSE_DRIVER_CHECK_EN
  ,
  input  logic               q_i,
  input  logic               q_n_i,
  output logic               check_err,
  output logic [7:0]         err_count
`endif
);
  import sr_pulse_pkg::*;
  localparam int CNT_W = (WIDTH_W > GAP_W + 1) ? WIDTH_W : GAP_W + 1;
  state_t state, state_d;
  op_t op_r, op_d;
  logic [CNT_W-1:0] cnt, cnt_d, w_ld;
  logic [GAP_W:0] gap_r, gap_d, g_sum;
  logic set_d, reset_d, done_d, rdy;
  logic [15:0] pc_d;
  assign w_ld = CNT_W'(cmd_width) - ((cmd_width != '0) ? CNT_W'(1) : CNT_W'(0));
  assign g_sum = (GAP_W+1)'(cmd_gap) + (GAP_W+1)'(MIN_GAP);
  assign cmd_ready = rdy && state == ST_IDLE;
  assign busy = state != ST_IDLE;
  always_comb begin
    state_d = state;
    op_d = op_r;
    cnt_d = cnt;
    gap_d = gap_r;
    set_d = set_o;
    reset_d = reset_o;
    done_d = 1'b0;
    pc_d = pulse_count;
    case (state)
      ST_IDLE: if (cmd_valid && rdy) begin
        state_d = ST_PULSE;
        op_d = op_t'(cmd_op);
        cnt_d = w_ld;
        gap_d = g_sum;
        set_d = op_d == OP_SET || op_d == OP_BOTH;
        reset_d = op_d == OP_RESET || op_d == OP_BOTH;
        pc_d = (op_d != OP_NOP && pulse_count != PULSE_CNT_MAX) ? pulse_count + 16'd1 : pulse_count;
      end
      ST_PULSE: if (cnt == '0) begin
        state_d = ST_GAP;
        cnt_d = CNT_W'(gap_r) - CNT_W'(1);
        set_d = 1'b0;
        reset_d = 1'b0;
      end else cnt_d = cnt - CNT_W'(1);
      ST_GAP: if (cnt == '0) begin
        state_d = ST_IDLE;
        done_d = 1'b1;
      end else cnt_d = cnt - CNT_W'(1);
      default: begin
        state_d = ST_IDLE;
        set_d = 1'b0;
        reset_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      op_r <= OP_NOP;
      cnt <= '0;
      gap_r <= '0;
      set_o <= 1'b0;
      reset_o <= 1'b0;
      done <= 1'b0;
      pulse_count <= '0;
      rdy <= 1'b0;
    end else begin
      state <= state_d;
      op_r <= op_d;
      cnt <= cnt_d;
      gap_r <= gap_d;
      set_o <= set_d;
      reset_o <= reset_d;
      done <= done_d;
      pulse_count <= pc_d;
      rdy <= 1'b1;
    end
  end
`ifdef SR_PULSE_DRIVER_CHECK_EN
  logic q_s, qn_s, chk, bad;
  sync2 u_sync_q (.clk(clk), .rst_n(rst_n), .d(q_i), .q(q_s));
  sync2 u_sync_qn (.clk(clk), .rst_n(rst_n), .d(q_n_i), .q(qn_s));
  // Short gaps are skipped: the synchronizer output is not yet meaningful.
  assign chk = state == ST_GAP && cnt == '0 && gap_r >= (GAP_W+1)'(3) && (op_r == OP_SET || op_r == OP_RESET);
  assign bad = (op_r == OP_SET) ? !(q_s && !qn_s) : !(!q_s && qn_s);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      check_err <= 1'b0;
      err_count <= '0;
    end else if (chk && bad) begin
      check_err <= 1'b1;
      err_count <= (err_count != 8'hFF) ? err_count + 8'd1 : err_count;
    end
  end
`endif
endmodule

// File: tb/tb_sr_pulse_driver.sv
// tb_sr_pulse_driver: directed self-checking bench for sr_pulse_driver (default build)
module tb_sr_pulse_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = 2'b11;
  logic [7:0] cmd_width = '0;
  logic [7:0] cmd_gap = '0;
  logic set_o, reset_o, busy, done;
  logic [15:0] pulse_count;
  int checks = 0;
  int failures = 0;

  sr_pulse_driver dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_width(cmd_width), .cmd_gap(cmd_gap),
    .set_o(set_o), .reset_o(reset_o), .busy(busy), .done(done), .pulse_count(pulse_count)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #2;
    checks++;
    if ({set_o, reset_o, busy, done, cmd_ready} !== 5'b0 || pulse_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_hold got=%b cnt=%0d exp=00000 cnt=0", {set_o, reset_o, busy, done, cmd_ready}, pulse_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({set_o, reset_o, busy, done, cmd_ready} !== 5'b00001 || pulse_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_release got=%b cnt=%0d exp=00001 cnt=0", {set_o, reset_o, busy, done, cmd_ready}, pulse_count);
    end
  endtask

  // Issues one command from a negedge in cycle T and checks every cycle up to E.
  task automatic test_single_pulse(input string name, input logic [1:0] op, input logic [7:0] w,
                                   input logic [7:0] g, input logic [15:0] exp_cnt);
    int wl, e;
    logic [4:0] got, exp;
    wl = (w == 0) ? 1 : int'(w);
    e = wl + int'(g) + 2;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_width = w;
    cmd_gap = g;
    for (int k = 1; k <= e; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_width = 8'hAA;
      got = {set_o, reset_o, done, cmd_ready, busy};
      exp = {k <= wl && (op == 2'b00 || op == 2'b10), k <= wl && (op == 2'b01 || op == 2'b10), k == e, k == e, k < e};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%b exp=%b", name, k, got, exp);
      end
    end
    checks++;
    if (pulse_count !== exp_cnt) begin
      failures++;
      $display("FAIL %s_count got=%0d exp=%0d", name, pulse_count, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] got, exp;
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_width = 8'd2;
    cmd_gap = 8'd1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      cmd_op = 2'b01;
      if (k == 6) cmd_valid = 1'b0;
      got = {set_o, reset_o, done};
      exp = {k <= 2, k == 6 || k == 7, k == 5 || k == 10};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", k, got, exp);
      end
    end
    checks++;
    if (pulse_count !== 16'd5) begin
      failures++;
      $display("FAIL back_to_back_count got=%0d exp=5", pulse_count);
    end
  endtask

  task automatic test_async_reset();
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_width = 8'd200;
    cmd_gap = 8'd0;
    repeat (10) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    checks++;
    if (set_o !== 1'b1) begin
      failures++;
      $display("FAIL async_pre got=%b exp=1", set_o);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({set_o, reset_o, busy, done, cmd_ready} !== 5'b0 || pulse_count !== 16'd0) begin
      failures++;
      $display("FAIL async_drop got=%b cnt=%0d exp=00000 cnt=0", {set_o, reset_o, busy, done, cmd_ready}, pulse_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if ({set_o, busy, done, cmd_ready} !== 4'b0001 || pulse_count !== 16'd0) begin
        failures++;
        $display("FAIL async_after cyc=%0d got=%b cnt=%0d exp=0001 cnt=0", k, {set_o, busy, done, cmd_ready}, pulse_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse("set_w3_g2", 2'b00, 8'd3, 8'd2, 16'd1);
    test_single_pulse("reset_w0", 2'b01, 8'd0, 8'd0, 16'd2);
    test_single_pulse("both_w5", 2'b10, 8'd5, 8'd0, 16'd3);
    test_single_pulse("nop_w5", 2'b11, 8'd5, 8'd3, 16'd3);
    test_back_to_back();
    test_single_pulse("max_fields", 2'b00, 8'hFF, 8'hFF, 16'd6);
    test_async_reset();
    test_single_pulse("set_after_rst", 2'b00, 8'd1, 8'd0, 16'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
